// File: rtl/aes_sbox_seq.sv
// Time-multiplexed AES SubBytes / InvSubBytes engine: substitutes a bundle of 128-bit blocks
// LANES bytes per cycle, in place, inside a single buffer that also drives the result port.
module aes_sbox_seq #(
  parameter int unsigned NUM_BLOCKS = 11,
  parameter int unsigned LANES      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      in_inv_i,
  input  logic [128*NUM_BLOCKS-1:0] in_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [128*NUM_BLOCKS-1:0] out_data_o,
  output logic                      busy_o
);

  localparam int unsigned TotalBytes = 16 * NUM_BLOCKS;
  localparam int unsigned DataW      = 8 * TotalBytes;
  localparam int unsigned Steps      = TotalBytes / LANES;
  localparam int unsigned CntW       = (Steps > 1) ? $clog2(Steps) : 1;
  localparam int unsigned ChunkW     = 8 * LANES;
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  if ((TotalBytes % LANES) != 0) begin : gen_lanes_check
    $error("aes_sbox_seq: LANES must divide 16*NUM_BLOCKS");
  end

  // Entry i sits at bits [(255-i)*8 +: 8], so row 0 of the table reads left to right.
  localparam logic [2047:0] SboxFwd = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SboxInv = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_lookup(input logic inv, input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return inv ? SboxInv[idx +: 8] : SboxFwd[idx +: 8];
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [DataW-1:0] buf_q, buf_d;

  logic              accept;
  logic [31:0]       chunk_base;
  logic [ChunkW-1:0] chunk_in;
  logic [ChunkW-1:0] chunk_out;

  assign in_ready_o  = (state_q == StIdle) || ((state_q == StDone) && out_ready_i);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q == StBusy);
  assign out_data_o  = buf_q;
  assign accept      = in_valid_i && in_ready_o;

  // Only the active chunk is routed through the lookup lanes.
  assign chunk_base = 32'(cnt_q) * 32'(ChunkW);
  assign chunk_in   = buf_q[chunk_base +: ChunkW];

  for (genvar l = 0; l < LANES; l++) begin : gen_lanes
    assign chunk_out[l*8 +: 8] = sbox_lookup(mode_q, chunk_in[l*8 +: 8]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    buf_d   = buf_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          buf_d   = in_data_i;
          mode_d  = in_inv_i;
          cnt_d   = '0;
          state_d = StBusy;
        end else if ((state_q == StDone) && out_ready_i) begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        buf_d[chunk_base +: ChunkW] = chunk_out;
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_aes_sbox_seq.sv
// Bench for aes_sbox_seq: three instances (LANES 16, 4, 176) driven with directed vectors and
// checked against hand constants and a GF(2^8) reference S-box model.
module tb_aes_sbox_seq;

  localparam int DW = 1408;

  logic          clk;
  logic          rst_n;
  logic          in_valid  [3];
  logic          in_ready  [3];
  logic          in_inv    [3];
  logic [DW-1:0] in_data   [3];
  logic          out_valid [3];
  logic          out_ready [3];
  logic [DW-1:0] out_data  [3];
  logic          busy      [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] fwd_m [256];
  logic [7:0] inv_m [256];

  aes_sbox_seq #(.NUM_BLOCKS(11), .LANES(16)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_inv_i(in_inv[0]),
    .in_data_i(in_data[0]), .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .out_data_o(out_data[0]), .busy_o(busy[0])
  );

  aes_sbox_seq #(.NUM_BLOCKS(11), .LANES(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_inv_i(in_inv[1]),
    .in_data_i(in_data[1]), .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .out_data_o(out_data[1]), .busy_o(busy[1])
  );

  aes_sbox_seq #(.NUM_BLOCKS(11), .LANES(176)) dut_c (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]), .in_inv_i(in_inv[2]),
    .in_data_i(in_data[2]), .out_valid_o(out_valid[2]), .out_ready_i(out_ready[2]),
    .out_data_o(out_data[2]), .busy_o(busy[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  // Reference S-box from first principles: multiplicative inverse then the affine map.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] model_sbox(input logic [7:0] x);
    logic [7:0] b;
    b = 8'h00;
    for (int c = 1; c < 256; c++) if (gmul(x, 8'(c)) == 8'h01) b = 8'(c);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [DW-1:0] apply_model(input logic [DW-1:0] d, input logic inv);
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 8; k++) r[k*8 +: 8] = inv ? inv_m[d[k*8 +: 8]] : fwd_m[d[k*8 +: 8]];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int w = 0; w < DW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    int idx;
    checks++;
    if (act !== exp) begin
      idx = 0;
      for (int k = DW / 8 - 1; k >= 0; k--) if (act[k*8 +: 8] !== exp[k*8 +: 8]) idx = k;
      errors++;
      $display("FAIL %s: first bad byte %0d got %02h expected %02h", name, idx,
               act[idx*8 +: 8], exp[idx*8 +: 8]);
    end
  endtask

  // Present a transaction (called #1 after a rising edge) and return #1 after the accept edge.
  task automatic start(input int i, input logic inv, input logic [DW-1:0] d, input string name);
    in_valid[i] = 1'b1;
    in_inv[i]   = inv;
    in_data[i]  = d;
    chk({name, " in_ready before accept"}, 32'(in_ready[i]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    in_inv[i]   = ~inv;
    in_data[i]  = ~d;
  endtask

  task automatic wait_done(input int i, input int steps, input string name);
    int cyc;
    int bad;
    cyc = 0;
    bad = 0;
    while (!out_valid[i] && cyc < steps + 20) begin
      if (busy[i] !== 1'b1 || in_ready[i] !== 1'b0) bad++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk({name, " latency"}, 32'(cyc), 32'(steps));
    chk({name, " busy while working"}, 32'(bad), 32'd0);
  endtask

  task automatic consume(input int i, input string name);
    out_ready[i] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[i] = 1'b0;
    chk({name, " out_valid after consume"}, 32'(out_valid[i]), 32'd0);
    chk({name, " in_ready after consume"}, 32'(in_ready[i]), 32'd1);
  endtask

  typedef struct packed {
    logic       inv;
    logic [7:0] fill;
    logic [7:0] exp;
  } vec_t;

  vec_t          vecs [9];
  logic [DW-1:0] d;
  logic [DW-1:0] e;
  logic [DW-1:0] held;
  int            bad;

  initial begin
    vecs[0] = '{inv: 1'b0, fill: 8'h00, exp: 8'h63};
    vecs[1] = '{inv: 1'b1, fill: 8'h63, exp: 8'h00};
    vecs[2] = '{inv: 1'b0, fill: 8'h53, exp: 8'hed};
    vecs[3] = '{inv: 1'b1, fill: 8'hed, exp: 8'h53};
    vecs[4] = '{inv: 1'b0, fill: 8'hff, exp: 8'h16};
    vecs[5] = '{inv: 1'b1, fill: 8'h16, exp: 8'hff};
    vecs[6] = '{inv: 1'b0, fill: 8'h01, exp: 8'h7c};
    vecs[7] = '{inv: 1'b1, fill: 8'h7c, exp: 8'h01};
    vecs[8] = '{inv: 1'b1, fill: 8'h00, exp: 8'h52};

    for (int x = 0; x < 256; x++) fwd_m[x] = model_sbox(8'(x));
    for (int x = 0; x < 256; x++) inv_m[fwd_m[x]] = 8'(x);

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      in_inv[i]    = 1'b0;
      in_data[i]   = '0;
      out_ready[i] = 1'b0;
    end

    #2;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset out_valid[%0d]", i), 32'(out_valid[i]), 32'd0);
      chk($sformatf("reset busy[%0d]", i), 32'(busy[i]), 32'd0);
      chk_data($sformatf("reset out_data[%0d]", i), out_data[i], '0);
    end
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("in_ready after reset[%0d]", i),
                                     32'(in_ready[i]), 32'd1);

    // Uniform-fill vectors on the default configuration.
    for (int v = 0; v < 9; v++) begin
      start(0, vecs[v].inv, {176{vecs[v].fill}}, $sformatf("vec%0d", v));
      wait_done(0, 11, $sformatf("vec%0d", v));
      chk_data($sformatf("vec%0d data", v), out_data[0], {176{vecs[v].exp}});
      consume(0, $sformatf("vec%0d", v));
    end

    // Inverse then forward round trip, feeding the result back.
    start(0, 1'b1, {176{8'h63}}, "rt inv");
    wait_done(0, 11, "rt inv");
    chk_data("rt inv data", out_data[0], {176{8'h00}});
    held = out_data[0];
    consume(0, "rt inv");
    start(0, 1'b0, held, "rt fwd");
    wait_done(0, 11, "rt fwd");
    chk_data("rt fwd data", out_data[0], {176{8'h63}});
    consume(0, "rt fwd");

    // Position-dependent random data on the default configuration.
    d = rand_data();
    start(0, 1'b0, d, "rand fwd");
    wait_done(0, 11, "rand fwd");
    chk_data("rand fwd data", out_data[0], apply_model(d, 1'b0));
    consume(0, "rand fwd");

    // Ordering / mix on LANES=4.
    d = '0;
    d[7:0] = 8'h53;
    d[1407:1400] = 8'hff;
    e = {176{8'h63}};
    e[7:0] = 8'hed;
    e[1407:1400] = 8'h16;
    start(1, 1'b0, d, "mix");
    wait_done(1, 44, "mix");
    chk_data("mix data", out_data[1], e);
    consume(1, "mix");

    d = rand_data();
    start(1, 1'b1, d, "rand inv l4");
    wait_done(1, 44, "rand inv l4");
    chk_data("rand inv l4 data", out_data[1], apply_model(d, 1'b1));
    consume(1, "rand inv l4");

    // Backpressure, then back-to-back handshake on one edge.
    start(0, 1'b0, {176{8'h53}}, "bp");
    wait_done(0, 11, "bp");
    held = out_data[0];
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_data[0] !== held || in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1) bad++;
    end
    chk("bp hold stable", 32'(bad), 32'd0);
    chk_data("bp held data", held, {176{8'hed}});
    in_valid[0]  = 1'b1;
    in_inv[0]    = 1'b1;
    in_data[0]   = {176{8'h16}};
    out_ready[0] = 1'b1;
    #1;
    chk("b2b in_ready follows out_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    in_data[0]   = '0;
    chk("b2b out_valid dropped", 32'(out_valid[0]), 32'd0);
    wait_done(0, 11, "b2b");
    chk_data("b2b data", out_data[0], {176{8'hff}});
    consume(0, "b2b");

    // Reset in the middle of BUSY.
    start(0, 1'b0, rand_data(), "mid rst");
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("mid rst busy before", 32'(busy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", 32'(out_valid[0]), 32'd0);
    chk("mid rst busy", 32'(busy[0]), 32'd0);
    chk_data("mid rst out_data", out_data[0], '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid rst in_ready after release", 32'(in_ready[0]), 32'd1);
    chk("mid rst out_valid after release", 32'(out_valid[0]), 32'd0);
    start(0, 1'b0, {176{8'hff}}, "post rst");
    wait_done(0, 11, "post rst");
    chk_data("post rst data", out_data[0], {176{8'h16}});
    consume(0, "post rst");

    // Single-step configuration.
    d = rand_data();
    start(2, 1'b1, d, "l176 inv");
    wait_done(2, 1, "l176 inv");
    chk_data("l176 inv data", out_data[2], apply_model(d, 1'b1));
    consume(2, "l176 inv");
    start(2, 1'b0, {176{8'h53}}, "l176 fwd");
    wait_done(2, 1, "l176 fwd");
    chk_data("l176 fwd data", out_data[2], {176{8'hed}});
    consume(2, "l176 fwd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_sbox_seq.md
Name: aes_sbox_seq

Overview:
- Parametrised, time-multiplexed AES byte-substitution engine for a bundle of NUM_BLOCKS 128-bit blocks (e.g. 11 round-key/state blocks).
- Supports forward SubBytes and InvSubBytes, selected per transaction.
- Runs LANES S-box lookups per cycle, so area trades against latency.
- Sits between the key-schedule/round datapath and its consumers, with valid/ready handshakes on both sides.

Parameters:
- NUM_BLOCKS, 11, number of 128-bit blocks per transaction; TOTAL_BYTES = 16*NUM_BLOCKS.
- LANES, 16, S-box lookups per cycle; must divide TOTAL_BYTES, otherwise elaboration error; STEPS = TOTAL_BYTES/LANES.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  engine can accept a transaction.
- in_inv  in  1  0 = forward S-box, 1 = inverse S-box; sampled with in_data.
- in_data  in  128*NUM_BLOCKS  flat blocks; byte k of block b at [(b*128)+(k*8) +: 8].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  128*NUM_BLOCKS  substituted blocks, same byte layout as in_data.
- busy  out  1  high in BUSY state.

Behaviour:
- Reset (async, rst_n=0): state IDLE, step counter 0, mode 0, data buffer all-zero.
  - Outputs: out_valid=0, busy=0, out_data=0, in_ready=1 after reset release.
- One internal buffer of TOTAL_BYTES holds both the working and the result data; out_data drives the buffer directly.
- Accept: in_valid && in_ready at a rising edge.
  - Latch in_data into the buffer and in_inv into the mode register.
  - Counter <= 0; state -> BUSY.
- IDLE: in_ready=1, out_valid=0.
- BUSY: in_ready=0, busy=1.
  - Each edge, replace buffer bytes [cnt*LANES .. cnt*LANES+LANES-1] with S(byte) or S^-1(byte) per the latched mode; then cnt <= cnt+1.
  - On the edge that processes chunk STEPS-1: cnt <= 0, state -> DONE.
  - Chunks are processed in ascending byte-index order.
- DONE: out_valid=1; out_data stable until accepted.
  - out_valid && out_ready: result consumed.
  - If in_valid is also high in the same cycle, the new transaction is accepted in that same edge (in_ready = out_ready in DONE) and state -> BUSY. Otherwise state -> IDLE.
- in_ready is combinational: (state==IDLE) || (state==DONE && out_ready).
- Latency: out_valid rises exactly STEPS cycles after the accept edge.
  - Throughput: one transaction per STEPS+1 cycles with back-to-back acceptance, STEPS+2 via IDLE.
- in_valid while BUSY: ignored (in_ready=0); the upstream producer holds its data.
- out_ready while not DONE: no effect.
- Edge case STEPS=1 (LANES=TOTAL_BYTES): BUSY lasts one cycle; the counter may be optimised away, but behaviour is identical.
- Reset asserted mid-BUSY or in DONE: immediate return to reset values; the partial result is discarded and never presented.
- Tables:
  - Forward table is the FIPS-197 S-box, e.g. S(00)=63, S(53)=ed, S(ff)=16.
  - Inverse table is the FIPS-197 inverse S-box, e.g. S^-1(63)=00, S^-1(ed)=53, S^-1(16)=ff.
  - Both are pure combinational lookups, replicated LANES times; no table reads outside the active chunk.
- Counter width: max(1, clog2(STEPS)); never exceeds STEPS-1.

Test Plan:
- Defaults (NUM_BLOCKS=11, LANES=16): all-zero in_data, in_inv=0, accept at edge 0 -> busy for edges 1-11; out_valid=1 after edge 11; every out_data byte = 63.
- Inverse mode: every in_data byte = 63, in_inv=1 -> all out_data bytes = 00 after 11 cycles. Then feed that result back with in_inv=0 -> all bytes 63 (round-trip).
- Ordering/mix: block 0 byte 0 = 53, block 10 byte 15 = ff, all other bytes 00, LANES=4 (44 steps) -> out_valid after 44 cycles. Out byte [7:0]=ed, byte [1407:1400]=16, all others 63. Check busy=1 throughout.
- Backpressure and back-to-back: hold out_ready=0 for 20 cycles after DONE -> out_data stable and in_ready=0 throughout. Then assert out_ready with in_valid=1 in the same cycle -> both handshakes complete on one edge; new result appears 11 cycles later.
- Reset mid-operation: assert rst_n=0 at BUSY step 5 -> out_valid=0, out_data=0, busy=0 immediately. After release, in_ready=1 and a fresh transaction completes correctly.
- LANES=176 (STEPS=1): random 1408-bit vector, in_inv=1 -> out_valid one cycle after accept; each byte matches the reference inverse table.
